// File: rtl/spi_slave.sv
// SPI mode-0 slave with single-byte TX and RX buffers.
// The SPI pins are synchronized into the CLK domain, and edges are detected on the synchronized
// copies. A three-state FSM (IDLE / SHIFT / ABORT) drives the shift registers. The host side
// sees single-entry buffers with full/empty flags and a sticky overrun flag.
module spi_slave #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              SCLK,
    input  logic              CS_N,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [DATA_W-1:0] DATA_IN,
    input  logic              WRITE,
    output logic              TX_FULL,
    output logic              TX_EMPTY,
    output logic [DATA_W-1:0] DATA_OUT,
    input  logic              READ,
    output logic              RX_FULL,
    output logic              RX_EMPTY,
    output logic              OVERRUN
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ABORT = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0] sclkSync_q;
    logic [SYNC_STAGES-1:0] csSync_q;
    logic [SYNC_STAGES-1:0] mosiSync_q;
    logic                   sclkPrev_q;
    logic                   csPrev_q;

    logic sclkS, csS, mosiS;
    logic sclkRise, sclkFall, csRise, csFall;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    bitCnt_q, bitCnt_d;
    logic [DATA_W-1:0]   rxShift_q, rxShift_d;
    logic [DATA_W-1:0]   txShift_q, txShift_d;
    logic [DATA_W-1:0]   txBuf_q, txBuf_d;
    logic                txFull_q, txFull_d;
    logic [DATA_W-1:0]   rxBuf_q, rxBuf_d;
    logic                rxFull_q, rxFull_d;
    logic                overrun_q, overrun_d;

    logic                txConsume;
    logic                byteDone;
    logic                readOk;
    logic [DATA_W-1:0]   rxByte;
    logic [DATA_W-1:0]   txLoad;

    // Synchronizer chains for the asynchronous SPI pins, plus the previous synchronized level used for edge detection
    always_ff @(posedge CLK) begin
        if (CLR) begin
            sclkSync_q <= '0;
            csSync_q   <= '1;
            mosiSync_q <= '0;
            sclkPrev_q <= 1'b0;
            csPrev_q   <= 1'b1;
        end else begin
            sclkSync_q[0] <= SCLK;
            csSync_q[0]   <= CS_N;
            mosiSync_q[0] <= MOSI;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclkSync_q[i] <= sclkSync_q[i-1];
                csSync_q[i]   <= csSync_q[i-1];
                mosiSync_q[i] <= mosiSync_q[i-1];
            end
            sclkPrev_q <= sclkSync_q[SYNC_STAGES-1];
            csPrev_q   <= csSync_q[SYNC_STAGES-1];
        end
    end

    assign sclkS    = sclkSync_q[SYNC_STAGES-1];
    assign csS      = csSync_q[SYNC_STAGES-1];
    assign mosiS    = mosiSync_q[SYNC_STAGES-1];
    assign sclkRise = sclkS & ~sclkPrev_q;
    assign sclkFall = ~sclkS & sclkPrev_q;
    assign csRise   = csS & ~csPrev_q;
    assign csFall   = ~csS & csPrev_q;

    // Next-state logic for the transfer FSM, the shift registers and both host-side buffers
    always_comb begin
        state_d   = state_q;
        bitCnt_d  = bitCnt_q;
        rxShift_d = rxShift_q;
        txShift_d = txShift_q;
        txBuf_d   = txBuf_q;
        txFull_d  = txFull_q;
        rxBuf_d   = rxBuf_q;
        rxFull_d  = rxFull_q;
        overrun_d = overrun_q;
        txConsume = 1'b0;
        byteDone  = 1'b0;
        rxByte    = {rxShift_q[DATA_W-2:0], mosiS};
        txLoad    = txFull_q ? txBuf_q : '0;
        readOk    = READ & rxFull_q;

        case (state_q)
            IDLE: begin
                if (csFall) begin
                    txShift_d = txLoad;
                    txConsume = 1'b1;
                    bitCnt_d  = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (csRise) begin
                    state_d = (bitCnt_q != '0) ? ABORT : IDLE;
                end else begin
                    if (sclkRise) begin
                        rxShift_d = rxByte;
                        bitCnt_d  = bitCnt_q + 1'b1;
                        byteDone  = (bitCnt_q == LAST_BIT);
                    end
                    if (sclkFall) begin
                        if (bitCnt_q == FULL_CNT) begin
                            txShift_d = txLoad;
                            txConsume = 1'b1;
                            bitCnt_d  = '0;
                        end else if (bitCnt_q != '0) begin
                            txShift_d = {txShift_q[DATA_W-2:0], 1'b0};
                        end
                    end
                end
            end
            ABORT: begin
                bitCnt_d  = '0;
                rxShift_d = '0;
                txShift_d = '0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (txConsume) begin
            txFull_d = 1'b0;
        end
        if (WRITE && (!txFull_q || txConsume)) begin
            txBuf_d  = DATA_IN;
            txFull_d = 1'b1;
        end

        if (readOk) begin
            rxFull_d = 1'b0;
        end
        if (byteDone) begin
            if (!rxFull_q || readOk) begin
                rxBuf_d  = rxByte;
                rxFull_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State register for the FSM, the shift registers and the buffers
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q   <= IDLE;
            bitCnt_q  <= '0;
            rxShift_q <= '0;
            txShift_q <= '0;
            txBuf_q   <= '0;
            txFull_q  <= 1'b0;
            rxBuf_q   <= '0;
            rxFull_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitCnt_q  <= bitCnt_d;
            rxShift_q <= rxShift_d;
            txShift_q <= txShift_d;
            txBuf_q   <= txBuf_d;
            txFull_q  <= txFull_d;
            rxBuf_q   <= rxBuf_d;
            rxFull_q  <= rxFull_d;
            overrun_q <= overrun_d;
        end
    end

    assign MISO     = (state_q == SHIFT) & ~CS_N & txShift_q[DATA_W-1];
    assign TX_FULL  = txFull_q;
    assign TX_EMPTY = ~txFull_q;
    assign RX_FULL  = rxFull_q;
    assign RX_EMPTY = ~rxFull_q;
    assign DATA_OUT = rxBuf_q;
    assign OVERRUN  = overrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed testbench for spi_slave: the bench acts as a mode-0 SPI master and as the host side.
module tb_spi_slave;

    logic       CLK;
    logic       CLR;
    logic       SCLK;
    logic       CS_N;
    logic       MOSI;
    logic       MISO;
    logic [7:0] DATA_IN;
    logic       WRITE;
    logic       TX_FULL;
    logic       TX_EMPTY;
    logic [7:0] DATA_OUT;
    logic       READ;
    logic       RX_FULL;
    logic       RX_EMPTY;
    logic       OVERRUN;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] misoByte;
    logic       rxSeen;

    spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .CLK(CLK),
        .CLR(CLR),
        .SCLK(SCLK),
        .CS_N(CS_N),
        .MOSI(MOSI),
        .MISO(MISO),
        .DATA_IN(DATA_IN),
        .WRITE(WRITE),
        .TX_FULL(TX_FULL),
        .TX_EMPTY(TX_EMPTY),
        .DATA_OUT(DATA_OUT),
        .READ(READ),
        .RX_FULL(RX_FULL),
        .RX_EMPTY(RX_EMPTY),
        .OVERRUN(OVERRUN)
    );

    // 100 MHz system clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%02h expected=%02h", tag, observed, expected);
        end
    endtask

    task automatic doWrite(input logic [7:0] value);
        DATA_IN = value;
        WRITE   = 1'b1;
        tick(1);
        WRITE   = 1'b0;
        tick(1);
    endtask

    task automatic doRead();
        READ = 1'b1;
        tick(1);
        READ = 1'b0;
        tick(1);
    endtask

    task automatic csLow();
        CS_N = 1'b0;
        tick(6);
    endtask

    task automatic csHigh();
        CS_N = 1'b1;
        tick(6);
    endtask

    // Mode-0 master: MOSI set while SCLK is low, MISO sampled just before the rising edge.
    // rxSeenOut is RX_FULL sampled 4 CLK cycles after the last rising edge.
    // readAtEnd pulses READ so that it lands on the cycle the slave completes the byte.
    task automatic applyStimulus(input logic [7:0] mosiByte, input int nBits, input bit readAtEnd,
                                 output logic [7:0] misoOut, output logic rxSeenOut);
        logic [7:0] shiftIn;
        shiftIn   = 8'h00;
        rxSeenOut = 1'b0;
        for (int i = 0; i < nBits; i++) begin
            MOSI = mosiByte[7-i];
            tick(6);
            shiftIn = {shiftIn[6:0], MISO};
            SCLK = 1'b1;
            if (i == nBits - 1) begin
                if (readAtEnd) begin
                    tick(2);
                    READ = 1'b1;
                    tick(1);
                    READ = 1'b0;
                    tick(1);
                end else begin
                    tick(4);
                end
                rxSeenOut = RX_FULL;
                tick(2);
            end else begin
                tick(6);
            end
            SCLK = 1'b0;
        end
        misoOut = shiftIn;
        tick(6);
    endtask

    // Directed test sequence
    initial begin
        CLR     = 1'b1;
        SCLK    = 1'b0;
        CS_N    = 1'b1;
        MOSI    = 1'b0;
        DATA_IN = 8'h00;
        WRITE   = 1'b0;
        READ    = 1'b0;
        $display("[TB] spi_slave directed test start");
        tick(3);
        CLR = 1'b0;
        tick(2);

        checkOutput("rst_tx_empty", {7'd0, TX_EMPTY}, 8'h01);
        checkOutput("rst_tx_full", {7'd0, TX_FULL}, 8'h00);
        checkOutput("rst_rx_empty", {7'd0, RX_EMPTY}, 8'h01);
        checkOutput("rst_rx_full", {7'd0, RX_FULL}, 8'h00);
        checkOutput("rst_data_out", DATA_OUT, 8'h00);
        checkOutput("rst_overrun", {7'd0, OVERRUN}, 8'h00);
        checkOutput("rst_miso", {7'd0, MISO}, 8'h00);

        // Basic receive with a zero TX byte
        doWrite(8'h00);
        checkOutput("basic_tx_full", {7'd0, TX_FULL}, 8'h01);
        csLow();
        applyStimulus(8'h43, 8, 1'b0, misoByte, rxSeen);
        checkOutput("basic_miso", misoByte, 8'h00);
        checkOutput("basic_rx_latency", {7'd0, rxSeen}, 8'h01);
        checkOutput("basic_data_out", DATA_OUT, 8'h43);
        doRead();
        checkOutput("basic_rx_empty", {7'd0, RX_EMPTY}, 8'h01);
        checkOutput("basic_data_hold", DATA_OUT, 8'h43);
        csHigh();

        // Full duplex exchange
        doWrite(8'h5F);
        csLow();
        checkOutput("duplex_tx_empty", {7'd0, TX_EMPTY}, 8'h01);
        applyStimulus(8'hA5, 8, 1'b0, misoByte, rxSeen);
        checkOutput("duplex_miso", misoByte, 8'h5F);
        checkOutput("duplex_data_out", DATA_OUT, 8'hA5);
        checkOutput("duplex_rx_full", {7'd0, RX_FULL}, 8'h01);
        doRead();
        csHigh();

        // Back-to-back bytes without a READ in between
        csLow();
        applyStimulus(8'h11, 8, 1'b0, misoByte, rxSeen);
        applyStimulus(8'h22, 8, 1'b0, misoByte, rxSeen);
        csHigh();
        checkOutput("b2b_data_out", DATA_OUT, 8'h11);
        checkOutput("b2b_overrun", {7'd0, OVERRUN}, 8'h01);
        checkOutput("b2b_rx_full", {7'd0, RX_FULL}, 8'h01);
        CLR = 1'b1;
        tick(1);
        CLR = 1'b0;
        tick(2);
        checkOutput("clr_overrun", {7'd0, OVERRUN}, 8'h00);
        checkOutput("clr_rx_empty", {7'd0, RX_EMPTY}, 8'h01);
        checkOutput("clr_data_out", DATA_OUT, 8'h00);

        // Abort after five bits; the consumed TX byte is not re-queued
        doWrite(8'h9A);
        csLow();
        applyStimulus(8'hFF, 5, 1'b0, misoByte, rxSeen);
        checkOutput("abort_miso_bits", misoByte, 8'h13);
        csHigh();
        checkOutput("abort_rx_empty", {7'd0, RX_EMPTY}, 8'h01);
        checkOutput("abort_tx_empty", {7'd0, TX_EMPTY}, 8'h01);
        csLow();
        applyStimulus(8'h3C, 8, 1'b0, misoByte, rxSeen);
        checkOutput("abort_next_miso", misoByte, 8'h00);
        checkOutput("abort_next_data", DATA_OUT, 8'h3C);
        doRead();
        csHigh();

        // WRITE while full is ignored; READ coinciding with byte completion keeps the new byte
        doWrite(8'h81);
        doWrite(8'h7E);
        checkOutput("wfull_tx_full", {7'd0, TX_FULL}, 8'h01);
        csLow();
        applyStimulus(8'hC3, 8, 1'b0, misoByte, rxSeen);
        checkOutput("wfull_miso", misoByte, 8'h81);
        checkOutput("coinc_first_data", DATA_OUT, 8'hC3);
        applyStimulus(8'h5A, 8, 1'b1, misoByte, rxSeen);
        checkOutput("wfull_second_miso", misoByte, 8'h00);
        checkOutput("coinc_data_out", DATA_OUT, 8'h5A);
        checkOutput("coinc_rx_full", {7'd0, RX_FULL}, 8'h01);
        checkOutput("coinc_overrun", {7'd0, OVERRUN}, 8'h00);
        csHigh();
        doRead();
        checkOutput("coinc_rx_empty", {7'd0, RX_EMPTY}, 8'h01);

        // Reset in the middle of a byte
        doWrite(8'hFF);
        csLow();
        checkOutput("midrst_miso_before", {7'd0, MISO}, 8'h01);
        applyStimulus(8'hB0, 3, 1'b0, misoByte, rxSeen);
        CLR = 1'b1;
        tick(1);
        checkOutput("midrst_miso", {7'd0, MISO}, 8'h00);
        checkOutput("midrst_tx_empty", {7'd0, TX_EMPTY}, 8'h01);
        checkOutput("midrst_rx_empty", {7'd0, RX_EMPTY}, 8'h01);
        checkOutput("midrst_data_out", DATA_OUT, 8'h00);
        checkOutput("midrst_overrun", {7'd0, OVERRUN}, 8'h00);
        CS_N = 1'b1;
        tick(2);
        CLR = 1'b0;
        tick(6);
        checkOutput("midrst_idle_rx", {7'd0, RX_EMPTY}, 8'h01);

        // Fresh transfer after the reset
        doWrite(8'h24);
        csLow();
        applyStimulus(8'h96, 8, 1'b0, misoByte, rxSeen);
        checkOutput("fresh_miso", misoByte, 8'h24);
        checkOutput("fresh_data_out", DATA_OUT, 8'h96);
        csHigh();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter: DATA_W, 8, byte width of shift registers and buffers (only 8 is verified).
REQ-002 Parameter: SYNC_STAGES, 2, flip-flop stages on SCLK, CS_N and MOSI before use.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 CLK  input  1  system clock; every register updates on its rising edge.
REQ-005 CLR  input  1  synchronous active-high reset; overrides all other inputs.
REQ-006 SCLK  input  1  SPI serial clock from the master; asynchronous to CLK.
REQ-007 CS_N  input  1  SPI chip select, active low; asynchronous to CLK.
REQ-008 MOSI  input  1  serial data from the master.
REQ-009 MISO  output  1  serial data to the master; driven 0 whenever CS_N is high, never tri-stated.
REQ-010 DATA_IN  input  8  byte to transmit, captured on WRITE.
REQ-011 WRITE  input  1  one-cycle strobe that loads DATA_IN into the TX buffer.
REQ-012 TX_FULL / TX_EMPTY  output  1 each  TX buffer occupancy; always complementary.
REQ-013 DATA_OUT  output  8  last received byte; valid while RX_FULL=1.
REQ-014 READ  input  1  strobe that pops the RX buffer.
REQ-015 RX_FULL / RX_EMPTY  output  1 each  RX buffer occupancy; always complementary.
REQ-016 OVERRUN  output  1  sticky flag: a received byte was dropped.

Function
REQ-017 SPI mode is 0 (CPOL=0, CPHA=0), MSB first, 8 bits per byte, with back-to-back bytes allowed while CS_N stays low.
REQ-018 SCLK, CS_N and MOSI each pass through SYNC_STAGES flip-flops; SCLK edges are detected from the synchronized value only.
REQ-019 The block is guaranteed correct only for SCLK high and low phases of at least 4 CLK cycles each.
REQ-020 The FSM has three states: IDLE, SHIFT and ABORT.
REQ-021 IDLE: on a synchronized CS_N falling edge, load tx_shift from the TX buffer (or 0x00 if TX_EMPTY), mark the TX buffer empty, clear bit_cnt, and go to SHIFT.
REQ-022 SHIFT, synchronized SCLK rising edge: rx_shift <= {rx_shift[6:0], MOSI_sync} and bit_cnt increments.
REQ-023 SHIFT, synchronized SCLK falling edge with bit_cnt in 1..7: tx_shift shifts left by one.
REQ-024 SHIFT, falling edge after the 8th rising edge: reload tx_shift from the TX buffer (or 0x00 if empty) and clear bit_cnt.
REQ-025 MISO equals tx_shift[7] while in SHIFT, so the first bit is present before the first SCLK rising edge.
REQ-026 Byte completion (8th rising edge): the full rx byte is written to the RX buffer, and RX_FULL=1 no more than 4 CLK cycles after the raw SCLK edge.
REQ-027 Byte completion with RX_FULL=1 and no READ in the same cycle: the byte is discarded, DATA_OUT is unchanged, and OVERRUN is set.
REQ-028 Byte completion coinciding with READ: the new byte is stored, RX_FULL stays 1, and OVERRUN is not set.
REQ-029 READ with RX_EMPTY=1: ignored. READ otherwise: RX_FULL->0 on the next edge, with DATA_OUT holding its value.
REQ-030 WRITE with TX_FULL=1: ignored and the buffer is unchanged.
REQ-031 WRITE in the same cycle the TX buffer is consumed: the new byte is stored and TX_FULL ends at 1.
REQ-032 CS_N rising edge in SHIFT with bit_cnt not 0 (mid-byte): go to ABORT; the partial byte is discarded and the RX buffer is untouched.
REQ-033 ABORT lasts one cycle (clears bit_cnt, rx_shift and tx_shift) and then returns to IDLE.
REQ-034 CS_N rising edge in SHIFT with bit_cnt=0: return directly to IDLE.
REQ-035 A byte consumed from the TX buffer and then aborted is lost and is not re-queued.
REQ-036 SCLK edges while in IDLE have no effect.

Reset
REQ-037 CLR=1 at a CLK edge forces: state=IDLE, bit_cnt=0, shift registers=0, MISO=0, TX_FULL=0, TX_EMPTY=1, RX_FULL=0, RX_EMPTY=1, DATA_OUT=0x00, OVERRUN=0, and synchronizers to idle levels (SCLK=0, CS_N=1).
REQ-038 CLR asserted mid-transfer aborts the transfer immediately.
REQ-039 After a mid-transfer CLR, a new transfer starts only on a fresh CS_N falling edge.
REQ-040 OVERRUN is cleared only by CLR.

Verification
REQ-041 Basic RX: WRITE 0x00; CS_N low; master sends 0x43 -> RX_FULL=1, DATA_OUT=0x43, MISO bits all 0; READ -> RX_EMPTY=1.
REQ-042 Full duplex: WRITE 0x5F; master sends 0xA5 -> MISO carries 0x5F MSB first, DATA_OUT=0xA5, TX_EMPTY=1 after CS_N falls.
REQ-043 Back-to-back with overrun: two bytes 0x11, 0x22 under one CS_N low with no READ -> DATA_OUT=0x11, OVERRUN=1; CLR -> OVERRUN=0.
REQ-044 Abort: CS_N rises after 5 SCLK rising edges -> RX_EMPTY stays 1; next full byte 0x3C is received correctly.
REQ-045 Boundary events: WRITE while TX_FULL -> ignored; READ coinciding with byte completion -> new byte stored, OVERRUN=0.
REQ-046 Mid-transfer reset: CLR during bit 3 -> all outputs at their REQ-037 values next cycle; MISO=0.
